// File: rtl/sig_dump_host.sv
// sig_dump_host: signature dump engine for the compliance-test bus.
// Software programs a window [BEGIN, END) and writes START. The block then
// reads each word of the window from RAM over its host port and emits it on
// a valid/ready stream, one host read outstanding at a time.
//
// Optional feature macro: SIGDUMP_TIMEOUT_EN
//   defined   -> rvalid watchdog of TimeoutCycles cycles in WAIT; expiry sets err
//   undefined -> WAIT waits for rvalid indefinitely
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | nothing in progress, waiting for START
// REQ   | host read request asserted for ptr, waiting for grant
// WAIT  | read granted, waiting for host rvalid
// OUT   | word presented on the signature stream, waiting for ready
// DONE  | dump finished (done_o=1); START re-launches, CLEAR returns to IDLE

module sig_dump_host #(
    parameter int unsigned CountWidth    = 16,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        dev_req_i,
    input  logic        dev_we_i,
    input  logic [31:0] dev_addr_i,
    input  logic [3:0]  dev_be_i,
    input  logic [31:0] dev_wdata_i,
    output logic        dev_rvalid_o,
    output logic [31:0] dev_rdata_o,
    output logic        dev_err_o,

    output logic        host_req_o,
    input  logic        host_gnt_i,
    output logic [31:0] host_addr_o,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    input  logic        host_err_i,

    output logic        sig_valid_o,
    input  logic        sig_ready_i,
    output logic [31:0] sig_data_o,

    output logic        done_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_OUT,
        ST_DONE
    } state_t;

    localparam logic [1:0] RegBegin = 2'd0;
    localparam logic [1:0] RegEnd   = 2'd1;
    localparam logic [1:0] RegCtrl  = 2'd2;
    localparam logic [1:0] RegCount = 2'd3;

    state_t                state;
    logic [31:0]           begin_addr;
    logic [31:0]           end_addr;
    logic [31:0]           ptr;
    logic [31:0]           ptr_next;
    logic [CountWidth-1:0] count;
    logic                  err;
    logic                  busy;

    logic [1:0]            reg_sel;
    logic                  dev_wr;
    logic                  be_full;
    logic                  wr_begin;
    logic                  wr_end;
    logic                  wr_ctrl;
    logic                  wr_err;
    logic                  start_cmd;
    logic                  clear_cmd;
    logic                  launch;
    logic [31:0]           rd_data;

    // Only bits [3:2] of the device address select a register.
    logic                  unused_dev_addr;
    assign unused_dev_addr = ^{dev_addr_i[31:4], dev_addr_i[1:0]};

`ifdef SIGDUMP_TIMEOUT_EN
    localparam int unsigned        WdogWidth = $clog2(TimeoutCycles) + 1;
    localparam logic [WdogWidth-1:0] WdogLoad = WdogWidth'(TimeoutCycles - 1);
    logic [WdogWidth-1:0] wdog;
`else
    localparam int unsigned unused_timeout_cycles = TimeoutCycles;
`endif

    assign busy     = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_OUT);
    assign ptr_next = ptr + 32'd4;

    // Device port write decode; partial writes never take effect.
    assign reg_sel  = dev_addr_i[3:2];
    assign dev_wr   = dev_req_i && dev_we_i;
    assign be_full  = (dev_be_i == 4'hF);
    assign wr_begin = dev_wr && be_full && (reg_sel == RegBegin) && !busy;
    assign wr_end   = dev_wr && be_full && (reg_sel == RegEnd) && !busy;
    assign wr_ctrl  = dev_wr && be_full && (reg_sel == RegCtrl);
    assign wr_err   = dev_wr && (!be_full
                                 || (reg_sel == RegCount)
                                 || (busy && ((reg_sel == RegBegin) || (reg_sel == RegEnd))));

    assign start_cmd = wr_ctrl && dev_wdata_i[0];
    assign clear_cmd = wr_ctrl && dev_wdata_i[1];

    // START is honoured only when not busy; in DONE a simultaneous CLEAR wins.
    assign launch = start_cmd && ((state == ST_IDLE) || ((state == ST_DONE) && !clear_cmd));

    // Register read mux, sampled into the response register one cycle later.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            RegBegin: rd_data = begin_addr;
            RegEnd:   rd_data = end_addr;
            RegCtrl:  rd_data = {29'd0, busy, err, done_o};
            default:  rd_data = 32'(count);
        endcase
    end

    // Device port: window registers and the single-cycle-latency response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            begin_addr   <= '0;
            end_addr     <= '0;
            dev_rvalid_o <= 1'b0;
            dev_rdata_o  <= '0;
            dev_err_o    <= 1'b0;
        end else begin
            dev_rvalid_o <= dev_req_i;
            dev_err_o    <= wr_err;
            dev_rdata_o  <= (dev_req_i && !dev_we_i) ? rd_data : '0;
            if (wr_begin) begin
                begin_addr <= {dev_wdata_i[31:2], 2'b00};
            end
            if (wr_end) begin
                end_addr <= {dev_wdata_i[31:2], 2'b00};
            end
        end
    end

    // Dump sequencer with registered host, stream and done outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            count       <= '0;
            err         <= 1'b0;
            host_req_o  <= 1'b0;
            host_addr_o <= '0;
            sig_valid_o <= 1'b0;
            sig_data_o  <= '0;
            done_o      <= 1'b0;
`ifdef SIGDUMP_TIMEOUT_EN
            wdog        <= '0;
`endif
        end else if (launch) begin
            ptr   <= begin_addr;
            count <= '0;
            err   <= 1'b0;
            if (begin_addr >= end_addr) begin
                // Empty window: finish without touching the host port.
                state  <= ST_DONE;
                done_o <= 1'b1;
            end else begin
                state       <= ST_REQ;
                host_req_o  <= 1'b1;
                host_addr_o <= begin_addr;
                done_o      <= 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end

                ST_REQ: begin
                    if (host_gnt_i) begin
                        host_req_o <= 1'b0;
                        state      <= ST_WAIT;
`ifdef SIGDUMP_TIMEOUT_EN
                        wdog       <= WdogLoad;
`endif
                    end
                end

                ST_WAIT: begin
                    if (host_rvalid_i) begin
                        if (host_err_i) begin
                            err    <= 1'b1;
                            done_o <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            sig_data_o  <= host_rdata_i;
                            sig_valid_o <= 1'b1;
                            state       <= ST_OUT;
                        end
                    end
`ifdef SIGDUMP_TIMEOUT_EN
                    else if (wdog == '0) begin
                        err    <= 1'b1;
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        wdog <= wdog - 1'b1;
                    end
`endif
                end

                ST_OUT: begin
                    if (sig_ready_i) begin
                        sig_valid_o <= 1'b0;
                        ptr         <= ptr_next;
                        if (count != '1) begin
                            count <= count + 1'b1;
                        end
                        if (ptr_next >= end_addr) begin
                            done_o <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            host_req_o  <= 1'b1;
                            host_addr_o <= ptr_next;
                            state       <= ST_REQ;
                        end
                    end
                end

                ST_DONE: begin
                    if (clear_cmd) begin
                        done_o <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end

                default: begin
                    host_req_o  <= 1'b0;
                    sig_valid_o <= 1'b0;
                    done_o      <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sig_dump_host.sv
// tb_sig_dump_host: scoreboard bench for sig_dump_host. A RAM responder
// checks host addresses against an expected-address queue; a stream monitor
// checks emitted words against an expected-data queue. Scenario tasks push
// expectations, drive the device port and check register state inline.
`timescale 1ns/1ps

module tb_sig_dump_host;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        dev_req_i = 1'b0;
    logic        dev_we_i = 1'b0;
    logic [31:0] dev_addr_i = '0;
    logic [3:0]  dev_be_i = 4'hF;
    logic [31:0] dev_wdata_i = '0;
    logic        dev_rvalid_o;
    logic [31:0] dev_rdata_o;
    logic        dev_err_o;
    logic        host_req_o;
    logic        host_gnt_i = 1'b1;
    logic [31:0] host_addr_o;
    logic        host_rvalid_i = 1'b0;
    logic [31:0] host_rdata_i = '0;
    logic        host_err_i = 1'b0;
    logic        sig_valid_o;
    logic        sig_ready_i = 1'b1;
    logic [31:0] sig_data_o;
    logic        done_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    logic        rsp_pending = 1'b0;
    logic        rsp_hold = 1'b0;
    logic [31:0] rsp_addr = '0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    localparam logic [31:0] A_BEGIN = 32'h0;
    localparam logic [31:0] A_END   = 32'h4;
    localparam logic [31:0] A_CTRL  = 32'h8;
    localparam logic [31:0] A_COUNT = 32'hC;

    sig_dump_host #(
        .CountWidth(16),
        .TimeoutCycles(8)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .dev_req_i(dev_req_i),
        .dev_we_i(dev_we_i),
        .dev_addr_i(dev_addr_i),
        .dev_be_i(dev_be_i),
        .dev_wdata_i(dev_wdata_i),
        .dev_rvalid_o(dev_rvalid_o),
        .dev_rdata_o(dev_rdata_o),
        .dev_err_o(dev_err_o),
        .host_req_o(host_req_o),
        .host_gnt_i(host_gnt_i),
        .host_addr_o(host_addr_o),
        .host_rvalid_i(host_rvalid_i),
        .host_rdata_i(host_rdata_i),
        .host_err_i(host_err_i),
        .sig_valid_o(sig_valid_o),
        .sig_ready_i(sig_ready_i),
        .sig_data_o(sig_data_o),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    // RAM contents: words 1,2,3 at 0x100..0x108, an address-derived pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h10C) return ((a - 32'h100) >> 2) + 32'd1;
        return a ^ 32'hA5A5_0000;
    endfunction

    // RAM responder: rvalid one cycle after the grant unless held back.
    always @(negedge clk_i) begin
        host_rvalid_i = 1'b0;
        host_err_i    = 1'b0;
        host_rdata_i  = '0;
        if (rsp_pending && !rsp_hold) begin
            host_rvalid_i = 1'b1;
            host_rdata_i  = mem_word(rsp_addr);
            host_err_i    = (rsp_addr == err_addr);
            rsp_pending   = 1'b0;
        end
        if (host_req_o && host_gnt_i) begin
            n_cmp++;
            if (exp_addr_q.size() == 0) begin
                n_bad++;
                $display("FAIL host_addr: unexpected read of %h", host_addr_o);
            end else begin
                logic [31:0] e;
                e = exp_addr_q.pop_front();
                if (host_addr_o !== e) begin
                    n_bad++;
                    $display("FAIL host_addr: got %h expected %h", host_addr_o, e);
                end
            end
            rsp_pending = 1'b1;
            rsp_addr    = host_addr_o;
        end
    end

    // Stream monitor: every handshake must match the next expected word.
    always @(negedge clk_i) begin
        if (sig_valid_o && sig_ready_i) begin
            n_cmp++;
            if (exp_data_q.size() == 0) begin
                n_bad++;
                $display("FAIL sig_data: unexpected word %h", sig_data_o);
            end else begin
                logic [31:0] e;
                e = exp_data_q.pop_front();
                if (sig_data_o !== e) begin
                    n_bad++;
                    $display("FAIL sig_data: got %h expected %h", sig_data_o, e);
                end
            end
        end
    end

    task automatic dev_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             output logic err, output logic rv);
        @(posedge clk_i); #1;
        dev_req_i = 1'b1; dev_we_i = 1'b1; dev_addr_i = a; dev_wdata_i = d; dev_be_i = be;
        @(posedge clk_i); #1;
        dev_req_i = 1'b0; dev_we_i = 1'b0; dev_be_i = 4'hF;
        rv  = dev_rvalid_o;
        err = dev_err_o;
    endtask

    task automatic dev_read(input logic [31:0] a, output logic [31:0] d, output logic err,
                            output logic rv);
        @(posedge clk_i); #1;
        dev_req_i = 1'b1; dev_we_i = 1'b0; dev_addr_i = a; dev_be_i = 4'hF;
        @(posedge clk_i); #1;
        dev_req_i = 1'b0;
        rv  = dev_rvalid_o;
        err = dev_err_o;
        d   = dev_rdata_o;
    endtask

    task automatic push_window(input logic [31:0] b, input logic [31:0] e);
        for (logic [31:0] a = b; a < e; a += 32'd4) begin
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem_word(a));
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic er, rv;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        n_cmp++;
        if ({host_req_o, sig_valid_o, done_o, dev_rvalid_o, dev_err_o} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {host_req_o, sig_valid_o, done_o, dev_rvalid_o, dev_err_o});
        end
        dev_read(A_CTRL, d, er, rv);
        n_cmp++;
        if (d !== 32'd0 || er !== 1'b0 || rv !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %h err %b rv %b expected 0 0 1", d, er, rv);
        end
        dev_read(A_END, d, er, rv);
        n_cmp++;
        if (d !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_end: got %h expected 0", d);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d; logic er, rv;
        dev_write(A_BEGIN, 32'h0000_1237, 4'hF, er, rv);
        n_cmp++;
        if (er !== 1'b0 || rv !== 1'b1) begin
            n_bad++;
            $display("FAIL begin_write_rsp: err %b rv %b expected 0 1", er, rv);
        end
        @(posedge clk_i); #1;
        n_cmp++;
        if (dev_rvalid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rvalid_one_cycle: got %b expected 0", dev_rvalid_o);
        end
        dev_read(A_BEGIN, d, er, rv);
        n_cmp++;
        if (d !== 32'h0000_1234) begin
            n_bad++;
            $display("FAIL begin_align: got %h expected 00001234", d);
        end
        dev_write(A_END, 32'hABCD_EF03, 4'hF, er, rv);
        dev_read(A_END, d, er, rv);
        n_cmp++;
        if (d !== 32'hABCD_EF00) begin
            n_bad++;
            $display("FAIL end_align: got %h expected abcdef00", d);
        end
        dev_write(A_COUNT, 32'h5, 4'hF, er, rv);
        n_cmp++;
        if (er !== 1'b1) begin
            n_bad++;
            $display("FAIL count_write_err: got %b expected 1", er);
        end
        dev_read(A_COUNT, d, er, rv);
        n_cmp++;
        if (d !== 32'd0) begin
            n_bad++;
            $display("FAIL count_ro: got %h expected 0", d);
        end
    endtask

    task automatic run_window(input logic [31:0] b, input logic [31:0] e, input string tag,
                              input logic [31:0] exp_count, input logic [31:0] exp_ctrl);
        logic [31:0] d; logic er, rv;
        dev_write(A_BEGIN, b, 4'hF, er, rv);
        dev_write(A_END, e, 4'hF, er, rv);
        dev_write(A_CTRL, 32'h1, 4'hF, er, rv);
        for (int i = 0; i < 300 && !done_o; i++) begin
            @(posedge clk_i); #1;
        end
        n_cmp++;
        if (done_o !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_done: got %b expected 1", tag, done_o);
        end
        dev_read(A_COUNT, d, er, rv);
        n_cmp++;
        if (d !== exp_count) begin
            n_bad++;
            $display("FAIL %s_count: got %0d expected %0d", tag, d, exp_count);
        end
        dev_read(A_CTRL, d, er, rv);
        n_cmp++;
        if (d !== exp_ctrl) begin
            n_bad++;
            $display("FAIL %s_ctrl: got %b expected %b", tag, d[2:0], exp_ctrl[2:0]);
        end
        n_cmp++;
        if (exp_addr_q.size() != 0 || exp_data_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d addrs %0d words left expected 0 0", tag,
                     exp_addr_q.size(), exp_data_q.size());
            exp_addr_q.delete();
            exp_data_q.delete();
        end
    endtask

    task automatic test_basic();
        push_window(32'h100, 32'h10C);
        run_window(32'h100, 32'h10C, "basic", 32'd3, 32'b001);
    endtask

    task automatic test_back_to_back();
        logic er, rv;
        push_window(32'h100, 32'h10C);
        dev_write(A_CTRL, 32'h1, 4'hF, er, rv);
        n_cmp++;
        if (done_o !== 1'b0 || host_req_o !== 1'b1) begin
            n_bad++;
            $display("FAIL relaunch: done %b req %b expected 0 1", done_o, host_req_o);
        end
        for (int i = 0; i < 300 && !done_o; i++) begin
            @(posedge clk_i); #1;
        end
        n_cmp++;
        if (done_o !== 1'b1 || exp_data_q.size() != 0) begin
            n_bad++;
            $display("FAIL relaunch_done: done %b left %0d expected 1 0", done_o, exp_data_q.size());
        end
    endtask

    task automatic test_empty();
        logic [31:0] d; logic er, rv;
        dev_write(A_CTRL, 32'h2, 4'hF, er, rv);
        dev_write(A_BEGIN, 32'h200, 4'hF, er, rv);
        dev_write(A_END, 32'h200, 4'hF, er, rv);
        dev_write(A_CTRL, 32'h1, 4'hF, er, rv);
        n_cmp++;
        if (done_o !== 1'b1 || host_req_o !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_done: done %b req %b expected 1 0", done_o, host_req_o);
        end
        dev_read(A_COUNT, d, er, rv);
        n_cmp++;
        if (d !== 32'd0) begin
            n_bad++;
            $display("FAIL empty_count: got %0d expected 0", d);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        int word, stall;
        logic er, rv;
        word = 0; stall = 0; held = '0;
        sig_ready_i = 1'b0;
        push_window(32'h300, 32'h30C);
        dev_write(A_BEGIN, 32'h300, 4'hF, er, rv);
        dev_write(A_END, 32'h30C, 4'hF, er, rv);
        dev_write(A_CTRL, 32'h1, 4'hF, er, rv);
        for (int i = 0; i < 300 && !done_o; i++) begin
            @(posedge clk_i); #1;
            if (sig_valid_o) begin
                if (word == 1 && stall < 5) begin
                    sig_ready_i = 1'b0;
                    if (stall == 0) held = sig_data_o;
                    else begin
                        n_cmp++;
                        if (sig_data_o !== held) begin
                            n_bad++;
                            $display("FAIL stall_hold: got %h expected %h", sig_data_o, held);
                        end
                    end
                    n_cmp++;
                    if (host_req_o !== 1'b0) begin
                        n_bad++;
                        $display("FAIL stall_no_req: got %b expected 0", host_req_o);
                    end
                    stall++;
                end else begin
                    sig_ready_i = 1'b1;
                    word++;
                end
            end else begin
                sig_ready_i = 1'b0;
            end
        end
        sig_ready_i = 1'b1;
        n_cmp++;
        if (stall != 5 || word != 3 || done_o !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_progress: stall %0d words %0d done %b expected 5 3 1",
                     stall, word, done_o);
        end
    endtask

    task automatic test_host_err();
        err_addr = 32'h404;
        exp_addr_q.push_back(32'h400);
        exp_addr_q.push_back(32'h404);
        exp_data_q.push_back(mem_word(32'h400));
        run_window(32'h400, 32'h410, "host_err", 32'd1, 32'b011);
        err_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_clear_start();
        logic [31:0] d; logic er, rv;
        dev_write(A_CTRL, 32'h3, 4'hF, er, rv);
        n_cmp++;
        if (done_o !== 1'b0 || host_req_o !== 1'b0 || er !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_wins: done %b req %b err %b expected 0 0 0", done_o, host_req_o, er);
        end
        dev_read(A_CTRL, d, er, rv);
        n_cmp++;
        if ((d & 32'h5) !== 32'd0) begin
            n_bad++;
            $display("FAIL clear_ctrl: got %b expected busy=0 done=0", d[2:0]);
        end
    endtask

    task automatic test_busy_writes();
        logic [31:0] d; logic er, rv;
        sig_ready_i = 1'b0;
        push_window(32'h700, 32'h708);
        dev_write(A_BEGIN, 32'h700, 4'hF, er, rv);
        dev_write(A_END, 32'h708, 4'hF, er, rv);
        dev_write(A_CTRL, 32'h1, 4'hF, er, rv);
        for (int i = 0; i < 50 && !sig_valid_o; i++) begin
            @(posedge clk_i); #1;
        end
        dev_write(A_BEGIN, 32'h800, 4'hF, er, rv);
        n_cmp++;
        if (er !== 1'b1 || rv !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_begin_err: err %b rv %b expected 1 1", er, rv);
        end
        dev_read(A_BEGIN, d, er, rv);
        n_cmp++;
        if (d !== 32'h700) begin
            n_bad++;
            $display("FAIL busy_begin_kept: got %h expected 00000700", d);
        end
        dev_write(A_END, 32'h900, 4'h3, er, rv);
        n_cmp++;
        if (er !== 1'b1) begin
            n_bad++;
            $display("FAIL partial_be_err: got %b expected 1", er);
        end
        dev_write(A_CTRL, 32'h1, 4'hF, er, rv);
        n_cmp++;
        if (er !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_start_err: got %b expected 0", er);
        end
        dev_read(A_CTRL, d, er, rv);
        n_cmp++;
        if (d !== 32'b100) begin
            n_bad++;
            $display("FAIL busy_ctrl: got %b expected 100", d[2:0]);
        end
        sig_ready_i = 1'b1;
        for (int i = 0; i < 100 && !done_o; i++) begin
            @(posedge clk_i); #1;
        end
        dev_read(A_COUNT, d, er, rv);
        n_cmp++;
        if (d !== 32'd2 || exp_data_q.size() != 0) begin
            n_bad++;
            $display("FAIL busy_count: got %0d left %0d expected 2 0", d, exp_data_q.size());
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic er, rv;
        rsp_hold = 1'b1;
        exp_addr_q.push_back(32'h500);
`ifndef SIGDUMP_TIMEOUT_EN
        exp_addr_q.push_back(32'h504);
        exp_data_q.push_back(mem_word(32'h500));
        exp_data_q.push_back(mem_word(32'h504));
`endif
        dev_write(A_BEGIN, 32'h500, 4'hF, er, rv);
        dev_write(A_END, 32'h508, 4'hF, er, rv);
        dev_write(A_CTRL, 32'h1, 4'hF, er, rv);
        n_cmp++;
        if (host_req_o !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_req: got %b expected 1", host_req_o);
        end
        @(posedge clk_i); #1;
`ifdef SIGDUMP_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk_i); #1;
            n_cmp++;
            if (done_o !== (i == 8)) begin
                n_bad++;
                $display("FAIL timeout_cycle%0d: done %b expected %b", i, done_o, (i == 8));
            end
        end
        rsp_pending = 1'b0;
        rsp_hold    = 1'b0;
        dev_read(A_CTRL, d, er, rv);
        n_cmp++;
        if (d !== 32'b011) begin
            n_bad++;
            $display("FAIL timeout_ctrl: got %b expected 011", d[2:0]);
        end
`else
        repeat (100) @(posedge clk_i);
        dev_read(A_CTRL, d, er, rv);
        n_cmp++;
        if (d !== 32'b100) begin
            n_bad++;
            $display("FAIL no_watchdog_busy: got %b expected 100", d[2:0]);
        end
        rsp_hold = 1'b0;
        for (int i = 0; i < 100 && !done_o; i++) begin
            @(posedge clk_i); #1;
        end
        dev_read(A_COUNT, d, er, rv);
        n_cmp++;
        if (d !== 32'd2 || done_o !== 1'b1) begin
            n_bad++;
            $display("FAIL late_rvalid_count: got %0d done %b expected 2 1", d, done_o);
        end
`endif
    endtask

    task automatic test_reset_abort();
        logic [31:0] d; logic er, rv;
        logic seen;
        seen = 1'b0;
        rsp_hold = 1'b1;
        exp_addr_q.push_back(32'h900);
        dev_write(A_BEGIN, 32'h900, 4'hF, er, rv);
        dev_write(A_END, 32'h90C, 4'hF, er, rv);
        dev_write(A_CTRL, 32'h1, 4'hF, er, rv);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        rsp_hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            if (sig_valid_o || host_req_o || done_o) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_quiet: activity %b expected 0", seen);
        end
        dev_read(A_BEGIN, d, er, rv);
        n_cmp++;
        if (d !== 32'd0) begin
            n_bad++;
            $display("FAIL abort_begin: got %h expected 0", d);
        end
        dev_read(A_CTRL, d, er, rv);
        n_cmp++;
        if (d !== 32'd0) begin
            n_bad++;
            $display("FAIL abort_ctrl: got %b expected 000", d[2:0]);
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_basic();
        test_back_to_back();
        test_empty();
        test_stall();
        test_host_err();
        test_clear_start();
        test_busy_writes();
        test_timeout();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 500us");
        $fatal(1, "global timeout");
    end

endmodule
